// File: rtl/linebuf_scanout.sv
// linebuf_scanout: read side of the double-buffered line buffer.
// On each pixel strobe it fetches a 5-bit colour index, applies left-column
// blanking, display enable and backdrop substitution, then looks the index
// up in a 32 x 6-bit colour RAM and drives 12-bit RGB.
// Pipeline: stage 0 registers the read index and tags, stage 1 selects the
// index combinationally, stage 2 registers the CRAM read, and stage 3
// registers the expanded colour. Result: pix_en at T -> rgb_* at T+3.
// Build option LINEBUF_SCANOUT_BORDER_EN: when defined, border and blanked
// pixels show CRAM[{1, backdrop}]. When undefined, they show black.
module linebuf_scanout (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic       pix_en,
  input  logic       vactive,
  input  logic       display_en,
  input  logic       left_col_blank,
  input  logic [3:0] backdrop,
  input  logic [4:0] cram_wraddr,
  input  logic [5:0] cram_wrdata,
  input  logic       cram_wren,
  output logic [7:0] linebuf_rdidx,
  input  logic [4:0] linebuf_data,
  output logic [3:0] rgb_r,
  output logic [3:0] rgb_g,
  output logic [3:0] rgb_b,
  output logic       pixel_valid
);

  // A strobe that coincides with line_start is dropped.
  logic       accept;
  logic [8:0] hcnt;

  logic       s0_valid;
  logic       s0_active;
  logic       s0_x_lt8;

  logic       s1_use_lb;
  logic [4:0] s1_idx;

  logic       s2_valid;
  logic [5:0] s2_color;

  logic [5:0] cram [32];

  assign accept = pix_en && !line_start;

  // Horizontal pixel counter: restarts on line_start, saturates at 256.
  // NOTE: every clocked block uses non-blocking (<=) assignments.
  //       This makes all registers update together at the edge, so a
  //       register never sees a neighbour's new value early.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= 9'd256;
    end else if (line_start) begin
      hcnt <= 9'd0;
    end else if (pix_en && !hcnt[8]) begin
      hcnt <= hcnt + 9'd1;
    end
  end

  // Stage 0: issue the line buffer read and capture the per-pixel tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      linebuf_rdidx <= 8'd0;
      s0_valid      <= 1'b0;
      s0_active     <= 1'b0;
      s0_x_lt8      <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        linebuf_rdidx <= hcnt[7:0];
        s0_active     <= !hcnt[8] && vactive && display_en;
        s0_x_lt8      <= (hcnt < 9'd8);
      end
    end
  end

  // Stage 1: choose the line buffer index or the border index.
  // NOTE: every signal gets a default value at the top of always_comb.
  //       If some path left a signal unassigned, synthesis would infer a latch.
  always_comb begin
    s1_use_lb = 1'b0;
    s1_idx    = {1'b1, backdrop};
    if (s0_active && !(left_col_blank && s0_x_lt8)) begin
      s1_use_lb = 1'b1;
      s1_idx    = linebuf_data;
    end
  end

  // Stage 2: registered CRAM read.
  // A write in the same cycle lands at this same edge, so the read sees the
  // old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_color <= 6'd0;
    end else begin
      s2_valid <= s0_valid;
`ifdef LINEBUF_SCANOUT_BORDER_EN
      s2_color <= cram[s1_idx];
`else
      s2_color <= s1_use_lb ? cram[s1_idx] : 6'd0;
`endif
    end
  end

  // CPU write port into the colour RAM.
  // NOTE: this is a small flop array, not a RAM macro, so clearing every
  //       entry on reset costs only reset fan-out. Do not keep this pattern
  //       if the array is ever moved into a real RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cram[i] <= 6'd0;
      end
    end else if (cram_wren) begin
      cram[cram_wraddr] <= cram_wrdata;
    end
  end

  // Stage 3: expand each 2-bit channel to 4 bits by replication, then register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r       <= 4'd0;
      rgb_g       <= 4'd0;
      rgb_b       <= 4'd0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= s2_valid;
      if (s2_valid) begin
        rgb_r <= {2{s2_color[1:0]}};
        rgb_g <= {2{s2_color[3:2]}};
        rgb_b <= {2{s2_color[5:4]}};
      end
    end
  end

endmodule

// File: doc/linebuf_scanout.md
# linebuf_scanout

Scan-out stage on the read side of the double-buffered line buffer filled by the tile/sprite fetcher. On each pixel strobe it reads one 5-bit colour index from the line buffer, applies left-column blanking, display enable and backdrop substitution, then looks the index up in the 32-entry colour RAM (CRAM). It drives 12-bit RGB toward the video output path. It also owns the CPU-side CRAM write port.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- line_start  in  1  one-cycle pulse; the next 256 accepted pix_en strobes are active pixels 0..255
- pix_en  in  1  pixel strobe; may be asserted every cycle or sparsely
- vactive  in  1  current line is inside the active display area
- display_en  in  1  display enable (mode register)
- left_col_blank  in  1  blank pixels 0..7 to the backdrop colour
- backdrop  in  4  backdrop colour; indexes CRAM entry {1'b1, backdrop}
- cram_wraddr  in  5  CRAM write address
- cram_wrdata  in  6  CRAM write data, {B[1:0], G[1:0], R[1:0]}
- cram_wren  in  1  CRAM write strobe
- linebuf_rdidx  out  8  line buffer read index; registered
- linebuf_data  in  5  line buffer read data; valid one clk after linebuf_rdidx changes
- rgb_r, rgb_g, rgb_b  out  4 each  output colour
- pixel_valid  out  1  one-cycle pulse when rgb_* carries a new pixel

## Operation
- hcnt: 9-bit counter.
  - line_start sets hcnt to 0.
  - Each accepted pix_en increments hcnt, saturating at 256.
  - Active pixel: hcnt < 256, vactive = 1 and display_en = 1.
- Stage 0 (cycle of pix_en):
  - linebuf_rdidx <= hcnt[7:0].
  - Tag registers capture valid, active, and x_lt8 (hcnt < 8).
- Stage 1: index selection.
  - Index = linebuf_data when the pixel is active and not (left_col_blank && x_lt8).
  - Otherwise index = {1'b1, backdrop} (border index).
- Stage 2: CRAM read of the selected index, registered.
- Stage 3: expand each 2-bit channel to 4 bits by replication (2'b10 -> 4'b1010). Register onto rgb_*. pixel_valid = stage-3 valid tag.
- CRAM:
  - 32 x 6-bit register array.
  - A write takes effect at the clk edge of cram_wren.
  - A stage-2 read of the same entry in that cycle returns the old value (read-before-write).
- line_start and pix_en in the same cycle: line_start wins, that pix_en is dropped, hcnt = 0.
- line_start mid-line: restarts at pixel 0; pixels already in flight complete unchanged.
- Strobes after pixel 255 (hcnt = 256): border pixels, emitted with pixel_valid.
- Control inputs (display_en, left_col_blank, backdrop, vactive) are sampled at stage 0 or stage 1 as described, not re-sampled later.

## Timing
- Latency: pix_en at cycle T -> rgb_* and pixel_valid at T+3.
- Throughput: one pixel per clk.
- No backpressure; pix_en is never refused.
- Reset values: hcnt = 256; linebuf_rdidx = 0; rgb_* = 0; pixel_valid = 0; all pipeline valid tags = 0; all CRAM entries = 0.
- Reset mid-line flushes the pipeline; no pixel_valid until a new pix_en reaches stage 3.

## Configuration
- LINEBUF_SCANOUT_BORDER_EN
  - Defined: non-active pixels (hcnt = 256, !vactive, !display_en) and left-blanked pixels output CRAM[{1, backdrop}].
  - Undefined: those same pixels output rgb = 0 (black), with CRAM not consulted. Left-column blanking also outputs black.
  - pixel_valid timing is identical in both builds.

## Test plan
- Reset release; write CRAM[5] = 6'b11_01_10; line_start; buffer[0] = 5 -> first pixel_valid 3 clk after the first pix_en, rgb = (r = 4'hA, g = 4'h5, b = 4'hF).
- left_col_blank = 1, backdrop = 3, CRAM[19] = 6'h3F, buffer all 5 -> pixels 0..7 = 4'hF/F/F, pixel 8 = CRAM[5] colour.
- Continuous pix_en for 260 clk after line_start -> linebuf_rdidx steps 0..255; pixels 256..259 show the backdrop colour (BORDER_EN) or 0 (not defined).
- cram_wren to CRAM[5] in the same cycle index 5 is read in stage 2 -> that pixel shows the old colour, the next pixel the new one.
- line_start asserted at pixel 100 together with pix_en -> that strobe is dropped, next pix_en reads index 0, the three in-flight pixels still emerge.
- display_en = 0 with BORDER_EN -> all pixels = CRAM[{1, backdrop}]. Reset asserted mid-line -> rgb = 0 and pixel_valid = 0 the next cycle.
